// File: rtl/bsg_sort_sequencer.sv
// bsg_sort_sequencer: loads a batch, sorts it in place by odd-even transposition
// through an external compare-and-swap unit, then streams it out ascending.
module bsg_sort_sequencer #(
    parameter int width_p = 32,
    parameter int els_p   = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     data_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   yumi_i,
    output logic [2*width_p-1:0]   cas_data_o,
    output logic                   cas_swap_on_equal_o,
    input  logic [2*width_p-1:0]   cas_data_i,
    input  logic                   cas_swapped_i,
    output logic                   busy_o
);
    localparam int CW = $clog2(els_p);
    localparam logic [CW-1:0] TOP    = CW'(els_p - 1);
    localparam logic [CW-1:0] LAST_E = CW'((els_p % 2 == 0) ? els_p - 2 : els_p - 3);
    localparam logic [CW-1:0] LAST_O = CW'((els_p % 2 == 0) ? els_p - 3 : els_p - 2);

    typedef enum logic [1:0] {LOAD, SORT, UNLOAD} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, ph_q, ph_d, i_q, i_d, ip1;
    logic               any_swap_q, any_swap_d, prev_swap_q, prev_swap_d;
    logic               last_pair, swap_now;
    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] mem_d [els_p];

    assign cas_swap_on_equal_o = 1'b0;

    always_comb begin
        ip1         = i_q + CW'(1);
        last_pair   = i_q == (ph_q[0] ? LAST_O : LAST_E);
        swap_now    = any_swap_q | cas_swapped_i;
        state_d     = state_q;
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        i_d         = i_q;
        any_swap_d  = any_swap_q;
        prev_swap_d = prev_swap_q;
        mem_d       = mem_q;
        ready_o     = state_q == LOAD;
        v_o         = state_q == UNLOAD;
        busy_o      = state_q == SORT;
        data_o      = mem_q[cnt_q];
        cas_data_o  = '0;
        case (state_q)
            LOAD: if (v_i) begin
                mem_d[cnt_q] = data_i;
                cnt_d        = (cnt_q == TOP) ? '0 : cnt_q + CW'(1);
                state_d      = (cnt_q == TOP) ? SORT : LOAD;
            end
            SORT: begin
                cas_data_o   = {mem_q[ip1], mem_q[i_q]};
                mem_d[i_q]   = cas_data_i[width_p-1:0];
                mem_d[ip1]   = cas_data_i[2*width_p-1:width_p];
                any_swap_d   = swap_now;
                i_d          = i_q + CW'(2);
                // Two clean phases in a row mean the array is already ordered.
                if (last_pair && ((ph_q != '0 && !swap_now && !prev_swap_q) || ph_q == TOP)) begin
                    state_d     = UNLOAD;
                    ph_d        = '0;
                    i_d         = '0;
                    any_swap_d  = 1'b0;
                    prev_swap_d = 1'b0;
                end else if (last_pair) begin
                    ph_d        = ph_q + CW'(1);
                    i_d         = ph_q[0] ? CW'(0) : CW'(1);
                    prev_swap_d = swap_now;
                    any_swap_d  = 1'b0;
                end
            end
            UNLOAD: if (yumi_i) begin
                cnt_d   = (cnt_q == TOP) ? '0 : cnt_q + CW'(1);
                state_d = (cnt_q == TOP) ? LOAD : UNLOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            ph_q        <= '0;
            i_q         <= '0;
            any_swap_q  <= 1'b0;
            prev_swap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            i_q         <= i_d;
            any_swap_q  <= any_swap_d;
            prev_swap_q <= prev_swap_d;
        end
    end

    // Element storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_bsg_sort_sequencer.sv
// tb_bsg_sort_sequencer: vector table plus scoreboard for the sort sequencer,
// with a behavioural compare-and-swap unit attached.
module tb_bsg_sort_sequencer;
    localparam int W = 32;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset_i, v_i, yumi_i, ready_o, v_o, busy_o;
    logic           cas_swap_on_equal_o, cas_swapped_i;
    logic [W-1:0]   data_i, data_o, ca, cb;
    logic [2*W-1:0] cas_data_o, cas_data_i;

    bsg_sort_sequencer #(.width_p(W), .els_p(N)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .cas_data_o(cas_data_o),
        .cas_swap_on_equal_o(cas_swap_on_equal_o), .cas_data_i(cas_data_i),
        .cas_swapped_i(cas_swapped_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        ca            = cas_data_o[W-1:0];
        cb            = cas_data_o[2*W-1:W];
        cas_swapped_i = cas_swap_on_equal_o ? (ca >= cb) : (ca > cb);
        cas_data_i    = cas_swapped_i ? {ca, cb} : {cb, ca};
    end

    int swaps = 0;
    int eq_swaps = 0;
    always @(posedge clk) begin
        if (busy_o && cas_swapped_i) swaps <= swaps + 1;
        if (busy_o && cas_swapped_i && ca == cb) eq_swaps <= eq_swaps + 1;
    end

    typedef struct packed {
        logic [N-1:0][W-1:0] din;
        logic [N-1:0][W-1:0] dout;
        logic [7:0]          busy;
        logic                noswap;
        logic                stall;
    } vec_t;

    vec_t         tv [4];
    logic [W-1:0] sb [$];
    int           passed = 0;
    int           total = 0;

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_load(input logic [N-1:0][W-1:0] d);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            v_i    = 1'b1;
            data_i = d[k];
            chk("ready_in_load", ready_o, 1);
        end
        @(negedge clk);
        v_i = 1'b0;
    endtask

    task automatic count_busy(output int cyc);
        int g = 0;
        cyc = 0;
        while (!v_o && g < 200) begin
            if (busy_o) cyc++;
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("sort_timeout", 0, 1);
    endtask

    task automatic do_unload(input bit stall);
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   got = 0;
        int   g = 0;
        while (got < N && g < 200) begin
            chk("v_o_unload", v_o, 1);
            chk("ready_unload", ready_o, 0);
            yumi_i = stall ? pat[g % 7] : 1'b1;
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else begin
                chk("data_o", data_o, sb[0]);
                if (yumi_i) begin
                    void'(sb.pop_front());
                    got++;
                end
            end
            @(negedge clk);
            g++;
        end
        yumi_i = 1'b0;
        if (g >= 200) chk("unload_timeout", 0, 1);
        chk("ready_after_unload", ready_o, 1);
        chk("v_o_after_unload", v_o, 0);
    endtask

    initial begin
        int           cyc, s0, g;
        logic [W-1:0] acc [$];
        logic [W-1:0] srt [N];
        logic [W-1:0] tmp;
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready_o, 1);
        chk("rst_v_o", v_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cas_data", cas_data_o, 0);
        chk("swap_on_equal", cas_swap_on_equal_o, 0);
        reset_i = 1'b0;

        for (int k = 0; k < N; k++) begin
            tv[0].din[k]  = W'(N - k);
            tv[0].dout[k] = W'(k + 1);
            tv[1].din[k]  = W'(k + 1);
            tv[1].dout[k] = W'(k + 1);
        end
        tv[0].busy = 8'd28; tv[0].noswap = 1'b0; tv[0].stall = 1'b0;
        tv[1].busy = 8'd7;  tv[1].noswap = 1'b1; tv[1].stall = 1'b0;
        tv[2].din  = {32'd0, 32'd1, 32'd1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 32'd5};
        tv[2].dout = {32'hFFFFFFFF, 32'd5, 32'd5, 32'd5, 32'd1, 32'd1, 32'd0, 32'd0};
        tv[2].busy = 8'd0; tv[2].noswap = 1'b0; tv[2].stall = 1'b0;
        tv[3].din  = {32'd6, 32'd2, 32'd9, 32'd5, 32'd1, 32'd4, 32'd1, 32'd3};
        tv[3].dout = {32'd9, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd1};
        tv[3].busy = 8'd0; tv[3].noswap = 1'b0; tv[3].stall = 1'b1;

        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < N; k++) sb.push_back(tv[t].dout[k]);
            s0 = swaps;
            do_load(tv[t].din);
            count_busy(cyc);
            if (tv[t].busy != 0) chk("busy_cycles", cyc, tv[t].busy);
            if (tv[t].noswap) chk("no_swaps_sorted", swaps - s0, 0);
            do_unload(tv[t].stall);
        end
        chk("equal_pair_swaps", eq_swaps, 0);

        do_load(tv[0].din);
        repeat (9) @(negedge clk);
        chk("busy_mid_sort", busy_o, 1);
        reset_i = 1'b1;
        #1;
        chk("rst_mid_ready", ready_o, 1);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_v_o", v_o, 0);
        @(negedge clk);
        reset_i = 1'b0;
        for (int k = 0; k < N; k++) sb.push_back(tv[1].dout[k]);
        do_load(tv[1].din);
        count_busy(cyc);
        chk("busy_after_reset", cyc, 7);
        do_unload(1'b1);

        v_i = 1'b1;
        for (int b = 0; b < 2; b++) begin
            acc.delete();
            g = 0;
            while (ready_o && g < 100) begin
                data_i = $urandom;
                acc.push_back(data_i);
                @(negedge clk);
                g++;
            end
            chk("accepted_per_batch", acc.size(), N);
            for (int k = 0; k < N; k++) srt[k] = (k < acc.size()) ? acc[k] : '0;
            for (int a = 0; a < N; a++)
                for (int k = 0; k < N - 1 - a; k++)
                    if (srt[k] > srt[k+1]) begin
                        tmp      = srt[k];
                        srt[k]   = srt[k+1];
                        srt[k+1] = tmp;
                    end
            for (int k = 0; k < N; k++) sb.push_back(srt[k]);
            count_busy(cyc);
            do_unload(1'b0);
        end
        v_i = 1'b0;
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
